// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S transmitter with an integer bit-clock divider and a
// single-entry sample buffer behind a valid/ready handshake.
// Serial state advances only on bclk falling edges (fall events), which gives
// the standard one-bit delay between lrclk transitions and sample MSBs.
module i2s_tx #(
    parameter int BCLK_DIV = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din_left,
    input  logic [15:0] din_right,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun
);

    localparam int CW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic [31:0]   sr_q, sr_d;
    logic          buf_full_q, buf_full_d;
    logic [15:0]   buf_l_q, buf_l_d;
    logic [15:0]   buf_r_q, buf_r_d;
    logic          underrun_q, underrun_d;

    logic          tc_s;
    logic          fall_s;
    logic          accept_s;
    logic [4:0]    bit_nxt_s;

    assign tc_s      = (div_cnt_q == DIV_LAST);
    assign fall_s    = tc_s && bclk_q;
    assign accept_s  = din_valid && !buf_full_q;
    assign bit_nxt_s = bit_cnt_q + 5'd1;

    // Next-state logic for the divider, frame serialiser and sample buffer.
    always_comb begin
        div_cnt_d  = div_cnt_q;
        bclk_d     = bclk_q;
        bit_cnt_d  = bit_cnt_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        sr_d       = sr_q;
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        underrun_d = 1'b0;

        if (tc_s) begin
            div_cnt_d = CNT_ZERO;
            bclk_d    = ~bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + CNT_ONE;
        end

        if (fall_s) begin
            bit_cnt_d = bit_nxt_s;
            lrclk_d   = bit_nxt_s[4];
            sdata_d   = sr_q[31];
            if (bit_nxt_s == 5'd0) begin
                // Frame boundary: take the buffered pair, or send silence.
                if (buf_full_q) begin
                    sr_d       = {buf_l_q, buf_r_q};
                    buf_full_d = 1'b0;
                end else begin
                    sr_d       = 32'h0000_0000;
                    underrun_d = 1'b1;
                end
            end else begin
                sr_d = {sr_q[30:0], 1'b0};
            end
        end else begin
            sr_d = sr_q;
        end

        // An accept can only happen with the buffer empty, so it never
        // collides with the load above.
        if (accept_s) begin
            buf_full_d = 1'b1;
            buf_l_d    = din_left;
            buf_r_d    = din_right;
        end else begin
            buf_l_d = buf_l_q;
            buf_r_d = buf_r_q;
        end
    end

    // State registers with asynchronous reset to the idle frame position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= CNT_ZERO;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= 5'd31;
            lrclk_q    <= 1'b1;
            sdata_q    <= 1'b0;
            sr_q       <= 32'h0000_0000;
            buf_full_q <= 1'b0;
            buf_l_q    <= 16'h0000;
            buf_r_q    <= 16'h0000;
            underrun_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            sr_q       <= sr_d;
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            underrun_q <= underrun_d;
        end
    end

    assign din_ready = !buf_full_q;
    assign bclk      = bclk_q;
    assign lrclk     = lrclk_q;
    assign sdata     = sdata_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Testbench for i2s_tx: one instance at BCLK_DIV=8, one at BCLK_DIV=2.
// A per-instance cycle model predicts bclk/lrclk/underrun/din_ready and pushes
// the expected 32-bit frame word into a queue at each frame load; the bits
// sampled on bclk rises are reassembled and compared against that queue.
`timescale 1ns/1ps
module tb_i2s_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_w [2];
    logic [15:0] dl_w    [2];
    logic [15:0] dr_w    [2];
    logic        dv_w    [2];
    logic        rdy_w   [2];
    logic        bclk_w  [2];
    logic        lr_w    [2];
    logic        sd_w    [2];
    logic        und_w   [2];

    int          checks = 0;
    int          errors = 0;
    int          words_done [2] = '{0, 0};
    logic [31:0] last_word  [2] = '{32'h0, 32'h0};
    int          fall_bit   [2] = '{31, 31};
    bit          mfull      [2] = '{1'b0, 1'b0};
    int          cyc        [2] = '{0, 0};

    i2s_tx #(.BCLK_DIV(8)) dut8 (
        .clk(clk), .rst_n(rst_n_w[0]),
        .din_left(dl_w[0]), .din_right(dr_w[0]), .din_valid(dv_w[0]),
        .din_ready(rdy_w[0]), .bclk(bclk_w[0]), .lrclk(lr_w[0]),
        .sdata(sd_w[0]), .underrun(und_w[0])
    );

    i2s_tx #(.BCLK_DIV(2)) dut2 (
        .clk(clk), .rst_n(rst_n_w[1]),
        .din_left(dl_w[1]), .din_right(dr_w[1]), .din_valid(dv_w[1]),
        .din_ready(rdy_w[1]), .bclk(bclk_w[1]), .lrclk(lr_w[1]),
        .sdata(sd_w[1]), .underrun(und_w[1])
    );

    // Cycle model and frame scoreboard for instance idx with divider d.
    task automatic monitor(input int idx, input int d);
        int          p;
        bit          full;
        logic [15:0] bl, br;
        logic [31:0] q[$];
        logic [31:0] word, expw;
        logic        v;
        logic [15:0] l, r;
        bit          exp_und, acc, exp_bclk, exp_lr;
        int          f, n, b;
        p = 0; full = 1'b0; word = 32'h0; bl = 16'h0; br = 16'h0;
        forever begin
            @(posedge clk);
            v = dv_w[idx]; l = dl_w[idx]; r = dr_w[idx];
            #1;
            if (rst_n_w[idx] !== 1'b1) begin
                p = 0; full = 1'b0; q.delete(); word = 32'h0;
                fall_bit[idx] = 31; mfull[idx] = 1'b0; cyc[idx] = 0;
                checks++;
                if (und_w[idx] !== 1'b0) begin
                    errors++;
                    $display("FAIL underrun_in_reset[%0d]: got %b want 0", idx, und_w[idx]);
                end
            end else begin
                p++; cyc[idx] = p;
                exp_und = 1'b0;
                acc = v && !full;
                f = p / (2 * d);
                if ((p % (2 * d)) == 0) begin
                    b = (f - 1) % 32;
                    fall_bit[idx] = b;
                    if (b == 0) begin
                        if (full) begin
                            q.push_back({bl, br});
                            full = 1'b0;
                        end else begin
                            q.push_back(32'h0);
                            exp_und = 1'b1;
                        end
                    end
                end
                if (acc) begin
                    full = 1'b1; bl = l; br = r;
                end
                mfull[idx] = full;
                exp_bclk = ((p / d) % 2) == 1;
                exp_lr   = (f == 0) ? 1'b1 : (((f - 1) % 32) >= 16);
                checks++;
                if (bclk_w[idx] !== exp_bclk) begin
                    errors++;
                    $display("FAIL bclk[%0d] cyc %0d: got %b want %b", idx, p, bclk_w[idx], exp_bclk);
                end
                checks++;
                if (lr_w[idx] !== exp_lr) begin
                    errors++;
                    $display("FAIL lrclk[%0d] cyc %0d: got %b want %b", idx, p, lr_w[idx], exp_lr);
                end
                checks++;
                if (und_w[idx] !== exp_und) begin
                    errors++;
                    $display("FAIL underrun[%0d] cyc %0d: got %b want %b", idx, p, und_w[idx], exp_und);
                end
                checks++;
                if (rdy_w[idx] !== !full) begin
                    errors++;
                    $display("FAIL din_ready[%0d] cyc %0d: got %b want %b", idx, p, rdy_w[idx], !full);
                end
                if ((p % (2 * d)) == d) begin
                    n = (p + d) / (2 * d);
                    if (n <= 2) begin
                        checks++;
                        if (sd_w[idx] !== 1'b0) begin
                            errors++;
                            $display("FAIL sdata_start[%0d] rise %0d: got %b want 0", idx, n, sd_w[idx]);
                        end
                    end else begin
                        b = (n - 2) % 32;
                        if (b != 0) begin
                            word[32 - b] = sd_w[idx];
                        end else begin
                            word[0] = sd_w[idx];
                            checks++;
                            if (q.size() == 0) begin
                                errors++;
                                $display("FAIL word[%0d] cyc %0d: got %h but nothing expected", idx, p, word);
                            end else begin
                                expw = q.pop_front();
                                if (word !== expw) begin
                                    errors++;
                                    $display("FAIL word[%0d] cyc %0d: got %h want %h", idx, p, word, expw);
                                end
                            end
                            last_word[idx] = word;
                            words_done[idx]++;
                        end
                    end
                end
            end
        end
    endtask

    initial monitor(0, 8);
    initial monitor(1, 2);

    // Wait (bounded) until instance idx has completed target frame words.
    task automatic wait_words(input int idx, input int target, input int budget, output bit ok);
        int c;
        c = 0;
        while (words_done[idx] < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (words_done[idx] >= target);
    endtask

    task automatic test_reset();
        rst_n_w[0] = 1'b0; dv_w[0] = 1'b0; dl_w[0] = 16'h0; dr_w[0] = 16'h0;
        repeat (5) @(negedge clk);
        checks++; if (bclk_w[0] !== 1'b0) begin errors++; $display("FAIL reset_bclk: got %b want 0", bclk_w[0]); end
        checks++; if (lr_w[0] !== 1'b1) begin errors++; $display("FAIL reset_lrclk: got %b want 1", lr_w[0]); end
        checks++; if (sd_w[0] !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b want 0", sd_w[0]); end
        checks++; if (rdy_w[0] !== 1'b1) begin errors++; $display("FAIL reset_din_ready: got %b want 1", rdy_w[0]); end
        checks++; if (und_w[0] !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", und_w[0]); end
        rst_n_w[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 7) begin
                checks++; if (bclk_w[0] !== 1'b0) begin errors++; $display("FAIL bclk_before_rise: got %b want 0", bclk_w[0]); end
            end
            if (k == 8) begin
                checks++; if (bclk_w[0] !== 1'b1) begin errors++; $display("FAIL first_rise: got %b want 1", bclk_w[0]); end
            end
            if (k == 15) begin
                checks++; if (lr_w[0] !== 1'b1) begin errors++; $display("FAIL lrclk_before_fall: got %b want 1", lr_w[0]); end
            end
            if (k == 16) begin
                checks++; if (bclk_w[0] !== 1'b0) begin errors++; $display("FAIL first_fall_bclk: got %b want 0", bclk_w[0]); end
                checks++; if (lr_w[0] !== 1'b0) begin errors++; $display("FAIL first_fall_lrclk: got %b want 0", lr_w[0]); end
            end
        end
    endtask

    task automatic test_single_pair();
        bit ok;
        int base;
        rst_n_w[0] = 1'b0;
        repeat (2) @(negedge clk);
        base = words_done[0];
        rst_n_w[0] = 1'b1; dv_w[0] = 1'b1; dl_w[0] = 16'hA5C3; dr_w[0] = 16'h0F0F;
        @(negedge clk);
        dv_w[0] = 1'b0;
        checks++; if (rdy_w[0] !== 1'b0) begin errors++; $display("FAIL ready_after_accept: got %b want 0", rdy_w[0]); end
        wait_words(0, base + 1, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_pair_timeout: got %0d words want %0d", words_done[0] - base, 1); end
        checks++; if (last_word[0] !== 32'hA5C3_0F0F) begin errors++; $display("FAIL single_pair_word: got %h want a5c30f0f", last_word[0]); end
    endtask

    task automatic test_underrun();
        int np, nz, c;
        int stamp [3];
        np = 0; nz = 0; c = 0;
        stamp[0] = 0; stamp[1] = 0; stamp[2] = 0;
        while (np < 3 && c < 2200) begin
            @(negedge clk);
            c++;
            if (np > 0 && sd_w[0] !== 1'b0) nz++;
            if (und_w[0] === 1'b1) begin
                stamp[np] = cyc[0];
                np++;
            end
        end
        checks++; if (np != 3) begin errors++; $display("FAIL underrun_count: got %0d want 3", np); end
        checks++; if (stamp[1] - stamp[0] != 512) begin errors++; $display("FAIL underrun_spacing1: got %0d want 512", stamp[1] - stamp[0]); end
        checks++; if (stamp[2] - stamp[1] != 512) begin errors++; $display("FAIL underrun_spacing2: got %0d want 512", stamp[2] - stamp[1]); end
        checks++; if (nz != 0) begin errors++; $display("FAIL underrun_sdata: got %0d nonzero cycles want 0", nz); end
        @(negedge clk);
        checks++; if (und_w[0] !== 1'b0) begin errors++; $display("FAIL underrun_width: got %b want 0", und_w[0]); end
    endtask

    task automatic test_back_to_back();
        bit stop;
        stop = 1'b0;
        fork
            begin
                int k;
                bit prev;
                k = 0;
                dv_w[0] = 1'b1; dl_w[0] = 16'h1000; dr_w[0] = 16'h2000;
                prev = rdy_w[0];
                while (!stop) begin
                    @(negedge clk);
                    if (prev) begin
                        k++;
                        dl_w[0] = 16'h1000 + 16'(k);
                        dr_w[0] = 16'h2000 + 16'(k);
                    end
                    prev = rdy_w[0];
                end
                dv_w[0] = 1'b0;
            end
            begin
                bit ok;
                int got, tries;
                logic [15:0] prev_l;
                got = 0; tries = 0; prev_l = 16'h0;
                while (got < 4 && tries < 8) begin
                    wait_words(0, words_done[0] + 1, 700, ok);
                    tries++;
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL b2b_timeout: got %0d words want 4", got);
                        tries = 8;
                    end else if (last_word[0] != 32'h0) begin
                        if (got == 0) begin
                            if (last_word[0][31:16] !== 16'h1000) begin
                                errors++;
                                $display("FAIL b2b_first: got %h want 1000", last_word[0][31:16]);
                            end
                        end else if (last_word[0][31:16] !== prev_l + 16'h0001) begin
                            errors++;
                            $display("FAIL b2b_seq: got %h want %h", last_word[0][31:16], prev_l + 16'h0001);
                        end
                        checks++;
                        if (last_word[0][15:0] !== last_word[0][31:16] + 16'h1000) begin
                            errors++;
                            $display("FAIL b2b_right: got %h want %h", last_word[0][15:0], last_word[0][31:16] + 16'h1000);
                        end
                        prev_l = last_word[0][31:16];
                        got++;
                    end
                end
                checks++; if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got); end
                stop = 1'b1;
            end
        join
        @(negedge clk);
    endtask

    task automatic test_midframe_reset();
        bit ok;
        int c, base;
        c = 0;
        while (!(fall_bit[0] == 20 && mfull[0]) && c < 1200) begin
            @(negedge clk);
            c++;
        end
        checks++; if (!(fall_bit[0] == 20 && mfull[0])) begin errors++; $display("FAIL midreset_setup: got bit %0d full %b want 20 1", fall_bit[0], mfull[0]); end
        rst_n_w[0] = 1'b0;
        #1;
        checks++; if (bclk_w[0] !== 1'b0) begin errors++; $display("FAIL midreset_bclk: got %b want 0", bclk_w[0]); end
        checks++; if (lr_w[0] !== 1'b1) begin errors++; $display("FAIL midreset_lrclk: got %b want 1", lr_w[0]); end
        checks++; if (sd_w[0] !== 1'b0) begin errors++; $display("FAIL midreset_sdata: got %b want 0", sd_w[0]); end
        checks++; if (rdy_w[0] !== 1'b1) begin errors++; $display("FAIL midreset_din_ready: got %b want 1", rdy_w[0]); end
        checks++; if (und_w[0] !== 1'b0) begin errors++; $display("FAIL midreset_underrun: got %b want 0", und_w[0]); end
        repeat (3) @(negedge clk);
        base = words_done[0];
        rst_n_w[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 16) begin
                checks++; if (und_w[0] !== 1'b1) begin errors++; $display("FAIL midreset_first_underrun: got %b want 1", und_w[0]); end
            end
        end
        wait_words(0, base + 1, 1200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midreset_timeout: got %0d words want 1", words_done[0] - base); end
        checks++; if (last_word[0] !== 32'h0) begin errors++; $display("FAIL midreset_word: got %h want 00000000", last_word[0]); end
    endtask

    task automatic test_min_div();
        bit ok;
        int base;
        base = words_done[1];
        rst_n_w[1] = 1'b1; dv_w[1] = 1'b1; dl_w[1] = 16'h8001; dr_w[1] = 16'h7FFE;
        @(negedge clk);
        dv_w[1] = 1'b0;
        checks++; if (rdy_w[1] !== 1'b0) begin errors++; $display("FAIL min_ready: got %b want 0", rdy_w[1]); end
        @(negedge clk);
        checks++; if (bclk_w[1] !== 1'b1) begin errors++; $display("FAIL min_first_rise: got %b want 1", bclk_w[1]); end
        repeat (2) @(negedge clk);
        checks++; if (lr_w[1] !== 1'b0) begin errors++; $display("FAIL min_first_fall: got %b want 0", lr_w[1]); end
        wait_words(1, base + 1, 600, ok);
        checks++; if (last_word[1] !== 32'h8001_7FFE) begin errors++; $display("FAIL min_word: got %h want 80017ffe (ok=%b)", last_word[1], ok); end
        wait_words(1, base + 2, 600, ok);
        checks++; if (last_word[1] !== 32'h0 || !ok) begin errors++; $display("FAIL min_word_empty: got %h want 00000000 (ok=%b)", last_word[1], ok); end
    endtask

    initial begin
        rst_n_w[0] = 1'b0; rst_n_w[1] = 1'b0;
        dv_w[0] = 1'b0; dv_w[1] = 1'b0;
        dl_w[0] = 16'h0; dl_w[1] = 16'h0;
        dr_w[0] = 16'h0; dr_w[1] = 16'h0;
        test_reset();
        test_single_pair();
        test_underrun();
        test_back_to_back();
        test_midframe_reset();
        test_min_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
